// File: rtl/sqd_pkg.sv
// Shared types, constants and helpers for the programmable serial sequence detector.
package sqd_pkg;

  localparam logic OVERLAP_ON  = 1'b1;
  localparam logic OVERLAP_OFF = 1'b0;

  // Control state is derived from FILL and LEN, never stored separately.
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_FILLING  = 2'd1,
    ST_ARMED    = 2'd2
  } sqd_state_e;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic [31:0] clamp_len(input logic [31:0] len_in, input logic [31:0] max_len);
    return (len_in > max_len) ? max_len : len_in;
  endfunction

endpackage

// File: rtl/sqd_programmable_if.sv
// Serial data, pattern programming and match status bundle of the sequence detector.
interface sqd_programmable_if
  import sqd_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) ();

  logic               X;
  logic               X_VALID;
  logic               OVERLAP;
  logic               PAT_LOAD;
  logic [MAX_LEN-1:0] PAT_IN;
  logic [LEN_W-1:0]   LEN_IN;
  logic               CNT_CLR;
  logic               Z_OUT;
  logic [CNT_W-1:0]   MATCH_CNT;
  logic               ARMED;

  modport master (
    output X, X_VALID, OVERLAP, PAT_LOAD, PAT_IN, LEN_IN, CNT_CLR,
    input  Z_OUT, MATCH_CNT, ARMED
  );

  modport slave (
    input  X, X_VALID, OVERLAP, PAT_LOAD, PAT_IN, LEN_IN, CNT_CLR,
    output Z_OUT, MATCH_CNT, ARMED
  );

endinterface

// File: rtl/sqd_match_counter.sv
// Saturating match counter; a clear coinciding with a match restarts the count at one.
module sqd_match_counter
  import sqd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment but still counts the coinciding match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d    = {CNT_W{1'b0}};
      cnt_d[0] = inc_i;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sqd_programmable.sv
// Runtime-programmable serial sequence detector: compares the last LEN accepted bits
// against a loadable pattern and pulses Z_OUT on each (overlapping or not) match.
module sqd_programmable
  import sqd_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_1011,
  parameter int                 DEF_LEN = 4
) (
  input logic               CLK,
  input logic               RESET,
  sqd_programmable_if.slave bus
);

  localparam int               LEN_W     = len_w(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [MAX_LEN-1:0] PAT_ZERO = {MAX_LEN{1'b0}};
  localparam logic [LEN_W-1:0] DEF_LEN_C = LEN_W'(clamp_len(32'(DEF_LEN), 32'(MAX_LEN)));

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               z_q, z_d;
  logic               armed_q, armed_d;

  sqd_state_e         state_s;
  logic               accept_s;
  logic               match_s;
  logic [MAX_LEN-1:0] hist_shift_s;
  logic [MAX_LEN-1:0] len_mask_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [LEN_W-1:0]   len_load_s;

  // Decode the control state from the fill level.
  always_comb begin
    if (len_q == LEN_ZERO) begin
      state_s = ST_DISABLED;
    end else if (fill_q < len_q) begin
      state_s = ST_FILLING;
    end else begin
      state_s = ST_ARMED;
    end
  end

  // Candidate history, active-length mask and saturating fill for an accepted bit.
  always_comb begin
    accept_s     = bus.X_VALID & ~bus.PAT_LOAD;
    hist_shift_s = {hist_q[MAX_LEN-2:0], bus.X};
    len_load_s   = LEN_W'(clamp_len(32'(bus.LEN_IN), 32'(MAX_LEN)));
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask_s[i] = (i < int'(len_q));
    end
    case (state_s)
      ST_DISABLED: fill_inc_s = LEN_ZERO;
      ST_FILLING:  fill_inc_s = fill_q + 1'b1;
      ST_ARMED:    fill_inc_s = len_q;
      default:     fill_inc_s = LEN_ZERO;
    endcase
    match_s = accept_s && (state_s != ST_DISABLED) && (fill_inc_s == len_q) &&
              (((hist_shift_s ^ pat_q) & len_mask_s) == PAT_ZERO);
  end

  // Next-state: a pattern load restarts the window and swallows any same-cycle bit.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (bus.PAT_LOAD) begin
      pat_d  = bus.PAT_IN;
      len_d  = len_load_s;
      hist_d = PAT_ZERO;
      fill_d = LEN_ZERO;
    end else if (accept_s) begin
      hist_d = hist_shift_s;
      if (match_s && (bus.OVERLAP == OVERLAP_OFF)) begin
        fill_d = LEN_ZERO;
      end else begin
        fill_d = fill_inc_s;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
    z_d     = match_s;
    armed_d = (len_d != LEN_ZERO) && (fill_d == len_d);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pat_q   <= DEF_PAT;
      len_q   <= DEF_LEN_C;
      hist_q  <= PAT_ZERO;
      fill_q  <= LEN_ZERO;
      z_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      z_q     <= z_d;
      armed_q <= armed_d;
    end
  end

  sqd_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (bus.CNT_CLR),
    .inc_i (match_s),
    .cnt_o (bus.MATCH_CNT)
  );

  assign bus.Z_OUT = z_q;
  assign bus.ARMED = armed_q;

endmodule
